mmio_block_cipher_accel: RTL
============================

Name: mmio_block_cipher_accel

Overview:
- Memory-mapped encryption co-processor slave on the RISC-V core's data bus; next generation of the single-word byte-multiply accelerator.
- Generalised to NW-word key/plaintext/ciphertext blocks and LANES bytes processed per cycle, with a real IDLE/RUN/DONE engine.
- Each ciphertext byte is chained to the previous one; busy/done status and a step counter are readable.

Parameters:
- NW, 4: words per key/plaintext/ciphertext block; 1..8.
- LANES, 1: bytes processed per cycle; 1, 2 or 4.
- IDX_W, 5: word-index address bits; must satisfy 4+3*NW <= 2**IDX_W.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous reset, active-high.
- addr  in  32  byte address; word index = addr[IDX_W+1:2].
- wr_en  in  1  bus write strobe.
- accel_select  in  1  decoded chip select; writes take effect only when wr_en & accel_select.
- data_in  in  32  write data.
- data_out  out  32  combinational read data for addr.
- ctr  out  16  step counter, same value as COUNT register.

Behaviour:
- Word map (index):
  - 0 CTRL: write only, reads 0. bit0 = go, bit1 = clear.
  - 1 STATUS: {done, 29'b0, busy, 1'b0}.
  - 2 COUNT: {16'b0, counter}.
  - 3: reserved, reads 0.
  - 4..4+NW-1: KEY[j], read/write.
  - 4+NW..4+2NW-1: PT[j], read/write.
  - 4+2NW..4+3NW-1: CT[j], read only.
  - Unmapped indices read 0; writes to them are ignored.
- Reset: state IDLE, busy=0, done=0, counter=0, all KEY/PT/CT=0. data_out then follows the map, so it reads 0 except for registers addressed.
- Byte stream: i = 0..4NW-1, byte i = word i/4, bits 8*(i%4)+:8.
  - ct[i] = lo8(k[i]*p[i]) XOR ct[i-1], with ct[-1]=0.
  - Product is 8x8 truncated to 8 bits.
- STEPS = 4*NW/LANES.
- FSM:
  - IDLE, go write at edge E0 -> RUN. busy=1, counter=0, byte pointer=0.
  - RUN, each edge processes bytes ptr..ptr+LANES-1 (chained combinationally within the cycle, carry byte registered), writes them into CT, ptr += LANES, counter += 1.
  - The edge processing the last group -> DONE. busy=0, done=1. done is visible after E0+STEPS edges; counter holds at STEPS.
  - DONE, go write -> RUN. done=0, counter=0, CT overwritten progressively.
- Clear (CTRL bit1) in IDLE/DONE: CT=0, done=0, counter=0, state IDLE.
- Simultaneous go and clear in one write: go wins; clear is ignored.
- While busy:
  - Writes to KEY/PT/CTRL are ignored, including go and clear.
  - Reads are allowed; CT shows partial results.
- Counter does not wrap: max STEPS <= 32.
- rst mid-RUN aborts immediately to reset values.

Optional Feature:
- Macro ACCEL_IRQ_EN.
- Defined:
  - Adds port irq out 1 and CTRL bit2 = irq_enable (sticky, readable at STATUS bit2).
  - irq is registered and set on the RUN->DONE edge when enabled.
  - irq is cleared by a STATUS read with accel_select & ~wr_en, by clear, or by go.
- Undefined: no irq port; CTRL bit2 is ignored and STATUS bit2 reads 0.

Decomposition:
- Shared package holds:
  - Register index constants (CTRL, STATUS, COUNT, KEY_BASE, PT_BASE, CT_BASE as functions of NW).
  - CTRL bit positions.
  - FSM state typedef {IDLE, RUN, DONE}.
- One sub-module, cipher_lane_chain: combinational LANES-wide chain taking key/pt bytes and carry-in, producing ct bytes and carry-out. It instantiates LANES 8x8 truncating multipliers.

Test Plan:
1. Default params: KEY0=0x04030201, PT0=0x05050505, other KEY/PT 0, go -> busy for 16 edges; then done=1, COUNT=16, CT0=0x14000F05, CT1..3=0x14141414.
2. LANES=4, same data -> done after 4 edges, COUNT=4, identical CT values; STATUS polled each cycle shows busy until the done edge.
3. Write KEY0=0xFFFFFFFF during RUN, and go during RUN -> both ignored; final CT equals scenario 1 and COUNT stays 16.
4. After done, clear -> CT all 0, done=0, COUNT=0; then go+clear in one write -> run starts, busy=1.
5. Assert rst at step 7 of a run -> busy=0, done=0, all registers 0, data_out 0 on any address; read of index 3 and index 20 returns 0.
6. ACCEL_IRQ_EN defined: set irq_enable, go -> irq=1 on the done edge; STATUS read -> irq=0; with irq_enable=0, irq stays 0.

Source files
------------

// File: rtl/mmio_block_cipher_accel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmio_block_cipher_accel_pkg
// Description : Shared word map, CTRL/STATUS bit positions and engine states
//               for the MMIO block-cipher accelerator.
// Revision    : 1.0 - initial release
// ============================================================================
package mmio_block_cipher_accel_pkg;

    localparam int c_CTRL_IDX   = 0;
    localparam int c_STATUS_IDX = 1;
    localparam int c_COUNT_IDX  = 2;
    localparam int c_RSVD_IDX   = 3;
    localparam int c_KEY_BASE   = 4;

    localparam int c_CTRL_GO_BIT     = 0;
    localparam int c_CTRL_CLR_BIT    = 1;
    localparam int c_CTRL_IRQ_EN_BIT = 2;

    localparam int c_STATUS_BUSY_BIT   = 1;
    localparam int c_STATUS_IRQ_EN_BIT = 2;
    localparam int c_STATUS_DONE_BIT   = 31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } cipher_state_t;

    function automatic int pt_base(input int nw);
        return c_KEY_BASE + nw;
    endfunction

    function automatic int ct_base(input int nw);
        return c_KEY_BASE + 2 * nw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_block_cipher_accel_if.sv
`default_nettype none
// ============================================================================
// Module      : mmio_block_cipher_accel_if
// Description : Data-bus slave port of the accelerator (address, strobes,
//               write data and combinational read data).
// Revision    : 1.0 - initial release
// ============================================================================
interface mmio_block_cipher_accel_if;
    logic [31:0] addr;
    logic        wr_en;
    logic        accel_select;
    logic [31:0] data_in;
    logic [31:0] data_out;

    modport master (
        output addr,
        output wr_en,
        output accel_select,
        output data_in,
        input  data_out
    );

    modport slave (
        input  addr,
        input  wr_en,
        input  accel_select,
        input  data_in,
        output data_out
    );
endinterface
`default_nettype wire

// File: rtl/mmio_block_cipher_accel_cipher_lane_chain.sv
`default_nettype none
// ============================================================================
// Module      : cipher_lane_chain (+ cipher_mul8)
// Description : LANES-wide combinational byte chain: ct[l] = lo8(k*p) ^ ct[l-1],
//               fed by a registered carry byte from the previous cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module cipher_mul8 (
    input  wire logic [7:0] i_a,
    input  wire logic [7:0] i_b,
    output logic      [7:0] o_p
);
    // 8-bit context keeps only the low byte of the product
    assign o_p = i_a * i_b;
endmodule

module cipher_lane_chain
    import mmio_block_cipher_accel_pkg::*;
#(
    parameter int LANES = 1
) (
    input  wire logic [8*LANES-1:0] i_key,
    input  wire logic [8*LANES-1:0] i_pt,
    input  wire logic [7:0]         i_carry,
    output logic      [8*LANES-1:0] o_ct,
    output logic      [7:0]         o_carry
);
    logic [7:0] w_prod  [LANES];
    logic [7:0] w_chain [LANES+1];

    assign w_chain[0] = i_carry;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        cipher_mul8 u_mul (
            .i_a (i_key[8*l +: 8]),
            .i_b (i_pt[8*l +: 8]),
            .o_p (w_prod[l])
        );
        assign w_chain[l+1]   = w_prod[l] ^ w_chain[l];
        assign o_ct[8*l +: 8] = w_chain[l+1];
    end

    assign o_carry = w_chain[LANES];
endmodule
`default_nettype wire

// File: rtl/mmio_block_cipher_accel.sv
`default_nettype none
// ============================================================================
// Module      : mmio_block_cipher_accel
// Description : Memory-mapped chained byte-multiply cipher engine with
//               KEY/PT/CT register blocks. Optional irq via ACCEL_IRQ_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_block_cipher_accel
    import mmio_block_cipher_accel_pkg::*;
#(
    parameter int NW    = 4,
    parameter int LANES = 1,
    parameter int IDX_W = 5
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    mmio_block_cipher_accel_if.slave    bus,
    output logic [15:0]                 ctr
`ifdef ACCEL_IRQ_EN
    ,
    output logic                        irq
`endif
);
    localparam int c_NB     = 4 * NW;
    localparam int c_PTR_W  = $clog2(c_NB);
    localparam int c_BIT_W  = c_PTR_W + 3;
    localparam int c_KEY_LO = c_KEY_BASE;
    localparam int c_PT_LO  = pt_base(NW);
    localparam int c_CT_LO  = ct_base(NW);

    localparam logic [c_PTR_W-1:0] c_LAST_PTR  = c_PTR_W'(c_NB - LANES);
    localparam logic [c_PTR_W-1:0] c_PTR_STEP  = c_PTR_W'(LANES);

    cipher_state_t r_state;
    cipher_state_t w_state_nxt;

    logic [32*NW-1:0]   r_key;
    logic [32*NW-1:0]   r_pt;
    logic [32*NW-1:0]   r_ct;
    logic [c_PTR_W-1:0] r_ptr;
    logic [15:0]        r_cnt;
    logic [7:0]         r_carry;

    logic [31:0]        w_idx;
    logic               w_wr;
    logic               w_wr_ok;
    logic               w_ctrl_wr;
    logic               w_go;
    logic               w_clr;
    logic               w_last;
    logic               w_busy;
    logic               w_done;
    logic [c_BIT_W-1:0] w_bit_base;
    logic [8*LANES-1:0] w_lane_ct;
    logic [7:0]         w_lane_carry;
    logic [31:0]        w_status;
    logic [31:0]        w_rdata;
    logic               w_unused;

    assign w_idx     = 32'(bus.addr[IDX_W+1:2]);
    assign w_wr      = bus.wr_en & bus.accel_select;
    // Register writes (including CTRL) are locked out while the engine runs
    assign w_wr_ok   = w_wr & (r_state != ST_RUN);
    assign w_ctrl_wr = w_wr_ok & (w_idx == c_CTRL_IDX);
    assign w_go      = w_ctrl_wr & bus.data_in[c_CTRL_GO_BIT];
    assign w_clr     = w_ctrl_wr & bus.data_in[c_CTRL_CLR_BIT] & ~bus.data_in[c_CTRL_GO_BIT];
    assign w_last    = (r_state == ST_RUN) && (r_ptr == c_LAST_PTR);
    assign w_bit_base = {r_ptr, 3'b000};
    assign w_unused  = ^{bus.addr[31:IDX_W+2], bus.addr[1:0]};

    cipher_lane_chain #(
        .LANES (LANES)
    ) u_chain (
        .i_key   (r_key[w_bit_base +: 8*LANES]),
        .i_pt    (r_pt[w_bit_base +: 8*LANES]),
        .i_carry (r_carry),
        .o_ct    (w_lane_ct),
        .o_carry (w_lane_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_go) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (w_go) begin
                    w_state_nxt = ST_RUN;
                end else if (w_clr) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            ST_RUN:  w_busy = 1'b1;
            ST_DONE: w_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key   <= '0;
            r_pt    <= '0;
            r_ct    <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_carry <= '0;
        end else begin
            if (w_wr_ok) begin
                for (int j = 0; j < NW; j++) begin
                    if (w_idx == c_KEY_LO + j) begin
                        r_key[32*j +: 32] <= bus.data_in;
                    end
                    if (w_idx == c_PT_LO + j) begin
                        r_pt[32*j +: 32] <= bus.data_in;
                    end
                end
            end
            if (w_go) begin
                r_ptr   <= '0;
                r_cnt   <= '0;
                r_carry <= '0;
            end else if (w_clr) begin
                r_ct    <= '0;
                r_ptr   <= '0;
                r_cnt   <= '0;
                r_carry <= '0;
            end else if (r_state == ST_RUN) begin
                r_ct[w_bit_base +: 8*LANES] <= w_lane_ct;
                r_carry <= w_lane_carry;
                r_cnt   <= r_cnt + 16'd1;
                if (!w_last) begin
                    r_ptr <= r_ptr + c_PTR_STEP;
                end
            end
        end
    end

`ifdef ACCEL_IRQ_EN
    logic r_irq_en;
    logic r_irq;
    logic w_status_rd;

    assign w_status_rd = bus.accel_select & ~bus.wr_en & (w_idx == c_STATUS_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_irq_en <= bus.data_in[c_CTRL_IRQ_EN_BIT];
            end
            if (w_last && r_irq_en) begin
                r_irq <= 1'b1;
            end else if (w_status_rd || w_go || w_clr) begin
                r_irq <= 1'b0;
            end
        end
    end

    assign irq = r_irq;
`endif

    always_comb begin
        w_status                      = '0;
        w_status[c_STATUS_DONE_BIT]   = w_done;
        w_status[c_STATUS_BUSY_BIT]   = w_busy;
`ifdef ACCEL_IRQ_EN
        w_status[c_STATUS_IRQ_EN_BIT] = r_irq_en;
`endif
    end

    always_comb begin
        w_rdata = '0;
        if (w_idx == c_STATUS_IDX) begin
            w_rdata = w_status;
        end else if (w_idx == c_COUNT_IDX) begin
            w_rdata = {16'h0000, r_cnt};
        end
        for (int j = 0; j < NW; j++) begin
            if (w_idx == c_KEY_LO + j) begin
                w_rdata = r_key[32*j +: 32];
            end
            if (w_idx == c_PT_LO + j) begin
                w_rdata = r_pt[32*j +: 32];
            end
            if (w_idx == c_CT_LO + j) begin
                w_rdata = r_ct[32*j +: 32];
            end
        end
    end

    assign bus.data_out = w_rdata;
    assign ctr          = r_cnt;

endmodule
`default_nettype wire
